// File: rtl/fp_div_pkg.sv
// Shared types and constants for the run-time clock-divider controller.
package fp_div_pkg;
  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;
  localparam int DIV_MIN   = 2;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/fp_div_cnt.sv
// Period counter for the divider: counts 0..div-1 while running, flags the
// wrap cycle and decodes the divided clock and period-start tick.
module fp_div_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             out_clk,
  output logic             out_tick
);
  logic [CNT_W-1:0] cnt;

  assign wrap     = run && (cnt == div - CNT_W'(1));
  assign out_clk  = run && (cnt < (div >> 1));
  assign out_tick = run && (cnt == '0);

  // Counter held at zero whenever stopped, so a start always begins a fresh period.
  always_ff @(posedge clk) begin
    if (!rst || !run || load || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fp_div_ctrl.sv
// Divider controller: handshake, pending-request registers and the FSM that
// applies ratio/run changes only at period boundaries.
module fp_div_ctrl
  import fp_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 5
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_run,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             out_clk,
  output logic             out_tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             cfg_err
);
  state_t           state;
  logic             pend_run;
  logic [CNT_W-1:0] pend_div;
  logic             accept;
  logic             legal;
  logic             wrap;
  logic             running;
  logic             load;

  assign busy      = (state == DRAIN);
  assign cfg_ready = !busy;
  assign running   = (state != STOP);
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= CNT_W'(DIV_MIN));

  // A new ratio starts a fresh period from zero.
  always_comb begin
    load = 1'b0;
    case (state)
      STOP:    load = accept && cfg_run && legal;
      RUN:     load = accept && cfg_run && legal && wrap;
      DRAIN:   load = wrap && pend_run;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state    <= STOP;
      cur_div  <= CNT_W'(DEF_DIV);
      pend_run <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= accept && cfg_run && !legal;
      case (state)
        STOP: begin
          if (accept && cfg_run && legal) begin
            cur_div <= cfg_div;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept && (!cfg_run || legal)) begin
            // On the wrap itself the request lands at this boundary with no drain.
            if (wrap) begin
              if (cfg_run) cur_div <= cfg_div;
              else         state   <= STOP;
            end else begin
              pend_run <= cfg_run;
              pend_div <= cfg_div;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wrap) begin
            if (pend_run) begin
              cur_div <= pend_div;
              state   <= RUN;
            end else begin
              state <= STOP;
            end
          end
        end
        default: state <= STOP;
      endcase
    end
  end

  fp_div_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (in_clk),
    .rst      (in_rst),
    .run      (running),
    .load     (load),
    .div      (cur_div),
    .wrap     (wrap),
    .out_clk  (out_clk),
    .out_tick (out_tick)
  );
endmodule

// File: tb/tb_fp_div_ctrl.sv
// Self-checking bench for fp_div_ctrl: per-cycle scoreboard against a
// behavioural model plus directed checks of the documented waveforms.
module tb_fp_div_ctrl;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic             run;
  logic [CNT_W-1:0] div;
  logic             cfg_ready;
  logic             out_clk;
  logic             out_tick;
  logic [CNT_W-1:0] cur_div;
  logic             busy;
  logic             cfg_err;

  always #5 clk = ~clk;

  fp_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .in_clk    (clk),
    .in_rst    (rst),
    .cfg_valid (valid),
    .cfg_ready (cfg_ready),
    .cfg_run   (run),
    .cfg_div   (div),
    .out_clk   (out_clk),
    .out_tick  (out_tick),
    .cur_div   (cur_div),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  typedef struct packed {
    logic             clk_o;
    logic             tick;
    logic             bsy;
    logic             rdy;
    logic             err;
    logic [CNT_W-1:0] cdiv;
  } obs_t;

  obs_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: 0 = stop, 1 = run, 2 = drain.
  int m_state = 0;
  int m_cnt = 0;
  int m_div = DEF_DIV;
  int m_pend_div = 0;
  bit m_pend_run = 0;
  bit m_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.clk_o = (m_state != 0) && (m_cnt < (m_div / 2));
    o.tick  = (m_state != 0) && (m_cnt == 0);
    o.bsy   = (m_state == 2);
    o.rdy   = (m_state != 2);
    o.err   = m_err;
    o.cdiv  = CNT_W'(m_div);
    return o;
  endfunction

  task automatic model_edge();
    bit acc, wrap, leg;
    int ncnt;
    acc  = valid && (m_state != 2);
    wrap = (m_state != 0) && (m_cnt == m_div - 1);
    leg  = (div >= 2);
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_div = DEF_DIV; m_pend_run = 0; m_err = 0;
    end else begin
      m_err = acc && run && !leg;
      ncnt  = (m_state == 0 || wrap) ? 0 : m_cnt + 1;
      if (m_state == 0) begin
        if (acc && run && leg) begin m_div = div; m_state = 1; end
      end else if (m_state == 1) begin
        if (acc && (!run || leg)) begin
          if (wrap) begin
            if (run) m_div = div;
            else     m_state = 0;
          end else begin
            m_pend_run = run; m_pend_div = div; m_state = 2;
          end
        end
      end else if (wrap) begin
        if (m_pend_run) begin m_div = m_pend_div; m_state = 1; end
        else m_state = 0;
      end
      m_cnt = ncnt;
    end
  endtask

  task automatic step();
    obs_t e;
    @(posedge clk);
    model_edge();
    sb.push_back(model_obs());
    #1;
    e = sb.pop_front();
    check("scoreboard", {out_clk, out_tick, busy, cfg_ready, cfg_err, cur_div}, e);
  endtask

  task automatic request(input logic r, input logic [CNT_W-1:0] d);
    valid = 1'b1; run = r; div = d;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 50) begin n++; step(); end
    check("drain_bound", busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; valid = 1'b0; run = 1'b0; div = '0;
    step();
    step();
    check("rst_cur_div", cur_div, DEF_DIV);
    check("rst_ready", cfg_ready, 1);
    check("rst_clk", out_clk, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    step();

    // Start at N=5: tick in cycles 1, 6, 11; two high, three low.
    request(1'b1, 8'd5);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) step();
      check("n5_tick", out_tick, (k % 5) == 1);
      check("n5_clk", out_clk, ((k - 1) % 5) < 2);
    end

    // Change to N=2 with cnt=0 -> busy for cycles cnt=1..4.
    request(1'b1, 8'd2);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; step(); end
    check("n2_busy_len", n, 4);
    check("n2_cur_div", cur_div, 2);
    check("n2_tick0", out_tick, 1);
    check("n2_clk0", out_clk, 1);
    step();
    check("n2_tick1", out_tick, 0);
    check("n2_clk1", out_clk, 0);
    step();
    check("n2_tick2", out_tick, 1);

    // Move to N=4, then request N=3 exactly on the wrap cycle.
    request(1'b1, 8'd4);
    wait_idle();
    n = 0;
    while (m_cnt != 3 && n < 20) begin n++; step(); end
    request(1'b1, 8'd3);
    check("wrap_busy", busy, 0);
    check("wrap_cur_div", cur_div, 3);
    check("wrap_tick", out_tick, 1);
    check("wrap_clk_hi", out_clk, 1);
    step();
    check("wrap_clk_lo1", out_clk, 0);
    check("wrap_busy1", busy, 0);
    step();
    check("wrap_clk_lo2", out_clk, 0);
    step();
    check("wrap_period3", out_tick, 1);

    // Illegal ratio while running N=6.
    request(1'b1, 8'd6);
    wait_idle();
    step();
    step();
    request(1'b1, 8'd1);
    check("ill_err", cfg_err, 1);
    check("ill_busy", busy, 0);
    check("ill_cur_div", cur_div, 6);
    step();
    check("ill_err_once", cfg_err, 0);
    check("ill_cur_div2", cur_div, 6);

    // Stop while running N=7, accepted so the counter reaches 2.
    request(1'b1, 8'd7);
    wait_idle();
    n = 0;
    while (m_cnt != 1 && n < 20) begin n++; step(); end
    request(1'b0, 8'd0);
    check("stop_busy", busy, 1);
    wait_idle();
    check("stop_ready", cfg_ready, 1);
    for (int k = 0; k < 8; k++) begin
      check("stop_clk", out_clk, 0);
      check("stop_tick", out_tick, 0);
      step();
    end

    // Illegal start from STOP, then reset during DRAIN.
    request(1'b1, 8'd0);
    check("stop_ill_err", cfg_err, 1);
    check("stop_ill_clk", out_clk, 0);
    request(1'b1, 8'd4);
    check("start4_tick", out_tick, 1);
    request(1'b1, 8'd9);
    check("drain_busy", busy, 1);
    rst = 1'b0;
    step();
    check("rstd_busy", busy, 0);
    check("rstd_cur_div", cur_div, DEF_DIV);
    check("rstd_clk", out_clk, 0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("rstd_no_tick", out_tick, 0);
      check("rstd_div_kept", cur_div, DEF_DIV);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_div_ctrl.md
# fp_div_ctrl

Run-time controller for the team's integer clock-divider datapath. It accepts divide-ratio and run/stop requests over a valid/ready handshake and applies them only at output-period boundaries, so the divided waveform never has a runt pulse. It drives a registered single-edge divided clock, a period-start tick and status flags. It sits between the configuration/register logic and the divider consumers; everything runs on one clock.

## Interface
- `CNT_W`, default 8: width of the ratio and the period counter.
- `DEF_DIV`, default 5: ratio loaded at reset; must be ≥ 2.
- `in_clk` in 1: sole clock, rising edge.
- `in_rst` in 1: reset, synchronous, active-low.
- `cfg_valid` in 1: configuration request valid.
- `cfg_ready` out 1: controller can accept a request.
- `cfg_run` in 1: 1 = run at `cfg_div`; 0 = stop.
- `cfg_div` in CNT_W: requested ratio N. Legal range is 2..2^CNT_W−1.
- `out_clk` out 1: divided clock, registered.
- `out_tick` out 1: high for one cycle at the start of each period.
- `cur_div` out CNT_W: currently active ratio.
- `busy` out 1: a request is accepted but not yet applied.
- `cfg_err` out 1: one-cycle pulse when an illegal ratio is rejected.

## Operation
- A request is accepted on an edge where `cfg_valid && cfg_ready`.
- The FSM has three states:
  - `STOP`: counter held at 0, `out_clk`/`out_tick` low, `cfg_ready`=1.
  - `RUN`: counter `cnt` counts 0..N−1 and wraps; `cfg_ready`=1.
  - `DRAIN`: a change is pending; `cfg_ready`=0, `busy`=1; the counter keeps running on the old ratio.
- The wrap cycle is the cycle in which `cnt == cur_div−1`.
- Transitions:
  - `STOP`, accept run=1 with legal N: load `cur_div`←N, `cnt`←0, go to `RUN`.
  - `STOP`, accept run=0: no-op.
  - `RUN`, accept with legal N or run=0, not on the wrap cycle: capture the request into `pend_*` and go to `DRAIN`.
  - `RUN`, accept on the wrap cycle itself: apply the request at that same wrap. The FSM does not enter `DRAIN` and `busy` stays 0.
  - `DRAIN`, on the wrap cycle: if the pending request is run, load `cur_div`←`pend_div`, `cnt`←0 and go to `RUN`; if it is stop, go to `STOP`.
- Illegal requests: run=1 with N<2 is still accepted (handshake completes) but discarded. `cfg_err`=1 on the following cycle, and state, `cur_div` and `cnt` are unchanged. For run=0, `cfg_div` is ignored and never raises an error.
- Waveform in `RUN`/`DRAIN`, for the cycle holding counter value c:
  - `out_clk` = (c < N>>1), giving N>>1 cycles high and N−(N>>1) cycles low.
  - `out_tick` = (c == 0).
  - N is always `cur_div`.
- Reset values (`in_rst` low at an edge): state `STOP`, `cnt`=0, `cur_div`=`DEF_DIV`, `out_clk`=0, `out_tick`=0, `busy`=0, `cfg_err`=0, `cfg_ready`=1.
  - Reset mid-period or during `DRAIN` discards the pending request.
- Counter arithmetic is unsigned CNT_W bits; it never exceeds `cur_div`−1, so no overflow is possible.

## Timing
- Start from `STOP`: accept at edge k; in cycle k+1, `cnt`=0, `out_tick`=1, and `out_clk`=1 (for N≥2).
- Ratio change: the new N takes effect in the first cycle after the wrap; that cycle has `out_tick`=1.
  - Worst-case latency from accept is N_old cycles.
- Stop: the last full period completes; `out_clk`=0 from the cycle after the wrap.
- `busy` is high from the cycle after accept through the wrap cycle inclusive. `cfg_ready` = !`busy`.
- `cfg_err` asserts exactly one cycle, in the cycle after the illegal accept.
- All outputs are registered or decoded from state registers; there is no combinational path from inputs to outputs.

## Structure
- Package `fp_div_pkg`:
  - state enum `{STOP, RUN, DRAIN}`;
  - `DIV_MIN`=2;
  - default `CNT_W`.
- Sub-module `fp_div_cnt`: counter with synchronous load, wrap flag, and the `out_clk`/`out_tick` decode.
- `fp_div_ctrl`: the FSM, the pending registers and the handshake.

## Test plan
- Reset release, then accept run=1, N=5 → cycles 1..2 `out_clk`=1, cycles 3..5 `out_clk`=0, repeating with period 5; `out_tick` in cycles 1, 6, 11.
- While running N=5, request N=2 when `cnt`=1 → `busy` high for 4 cycles; after the wrap the period is 2 with 1 cycle high and 1 cycle low; `cur_div` updates to 2 at the first tick.
- Request N=3 exactly on the wrap cycle of N=4 → `busy` never asserts; the next period is 3 cycles (1 high, 2 low).
- Request run=1, N=1 while running N=6 → `cfg_err` pulses once, the waveform is undisturbed, `cur_div` stays 6.
- Request run=0 while running N=7 at `cnt`=2 → outputs continue until the wrap, then `out_clk`=0 and `out_tick`=0 indefinitely; `cfg_ready` returns to 1.
- Drive `in_rst` low during `DRAIN` → next cycle `STOP`, `cur_div`=`DEF_DIV`, `busy`=0, and the pending ratio is never applied.
